// File: rtl/mem_if_pkg.sv
// Shared L2 <-> memory line-interface definitions: widths, op type, responder FSM states.
// The L2 side imports ADDR_W/LINE_W from here as well.
package mem_if_pkg;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_resp_array.sv
// Line storage for the memory responder: 2^IDX_W x LINE_W, synchronous write, combinational read.
// Kept standalone so a vendor RAM macro can replace it without touching the FSM.
module mem_resp_array
    import mem_if_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the L2 line interface: one read/write at a time, mem_ready pulse LATENCY cycles after acceptance.
// No backpressure beyond busy; requests are only sampled in IDLE and are ignored while a transaction is outstanding.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 10,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              proto_err,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    resp_state_t       r_state, w_state_nxt;
    mem_op             r_op, w_op_sel;
    logic [IDX_W-1:0]  r_idx, w_idx_sel;
    logic [LINE_W-1:0] r_wdata, r_rdata, w_arr_rdata;
    logic [7:0]        r_lat_cnt;
    logic              r_ready, r_busy, r_perr;
    logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt;
    logic              w_accept, w_both, w_we;
    logic              w_unused_addr;

    // Upper address bits alias onto the same storage line.
    assign w_unused_addr = ^mem_addr[ADDR_W-1:IDX_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_both      = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end else if (mem_read && mem_write) begin
                    w_both = 1'b1;
                end
            end
            WAIT: begin
                if (r_lat_cnt <= 8'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the read data is loaded on the accepting edge, so look through to the live request.
    assign w_op_sel  = (r_state == IDLE) ? (mem_write ? OP_WR : OP_RD) : r_op;
    assign w_idx_sel = (r_state == IDLE) ? mem_addr[IDX_W-1:0] : r_idx;
    assign w_we      = (r_state == RESP) && (r_op == OP_WR);

    mem_resp_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wdata (r_wdata),
        .i_ridx  (w_idx_sel),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= OP_RD;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_lat_cnt <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_perr    <= 1'b0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_ready <= (w_state_nxt == RESP);
            if ((w_state_nxt == RESP) && (w_op_sel == OP_RD)) begin
                r_rdata <= w_arr_rdata;
            end
            if (w_accept) begin
                r_op      <= mem_write ? OP_WR : OP_RD;
                r_idx     <= mem_addr[IDX_W-1:0];
                r_wdata   <= mem_wdata;
                r_lat_cnt <= LAT_M1;
                r_busy    <= 1'b1;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt - 8'd1;
            end
            if (r_state == RESP) begin
                r_busy <= 1'b0;
                if (r_op == OP_RD) begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                end else begin
                    r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                end
            end
            if (w_both) begin
                r_perr <= 1'b1;
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = r_ready;
    assign busy      = r_busy;
    assign proto_err = r_perr;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 4, 1 with 4-bit counters, 7) against a line-array reference model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        rd [3];
    logic        wr [3];
    logic [27:0] addr [3];
    logic [127:0] wdat [3];
    logic [127:0] rdat [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        perr_o [3];
    logic [15:0] rdc [3];
    logic [15:0] wrc [3];
    logic [3:0]  rdc1, wrc1;

    int lat [3]   = '{4, 1, 7};
    int cmask [3] = '{32'hFFFF, 32'hF, 32'hFFFF};

    logic [127:0] mm [3][1024];
    bit           wrt [3][1024];
    logic [127:0] last [3];
    int           nrd [3];
    int           nwr [3];
    bit           perr_m [3];
    int           rcyc [3];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.LATENCY(4), .IDX_W(10), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdat[0]), .mem_rdata(rdat[0]), .mem_ready(rdy[0]),
        .busy(bsy[0]), .proto_err(perr_o[0]), .rd_cnt(rdc[0]), .wr_cnt(wrc[0])
    );

    mem_responder #(.LATENCY(1), .IDX_W(10), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdat[1]), .mem_rdata(rdat[1]), .mem_ready(rdy[1]),
        .busy(bsy[1]), .proto_err(perr_o[1]), .rd_cnt(rdc1), .wr_cnt(wrc1)
    );
    assign rdc[1] = {12'd0, rdc1};
    assign wrc[1] = {12'd0, wrc1};

    mem_responder #(.LATENCY(7), .IDX_W(10), .CNT_W(16)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .mem_read(rd[2]), .mem_write(wr[2]),
        .mem_addr(addr[2]), .mem_wdata(wdat[2]), .mem_rdata(rdat[2]), .mem_ready(rdy[2]),
        .busy(bsy[2]), .proto_err(perr_o[2]), .rd_cnt(rdc[2]), .wr_cnt(wrc[2])
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input int d, input string tag);
        chk({tag, "_rdata"}, rdat[d], last[d]);
        chk({tag, "_rdcnt"}, 128'(rdc[d]), 128'(nrd[d] & cmask[d]));
        chk({tag, "_wrcnt"}, 128'(wrc[d]), 128'(nwr[d] & cmask[d]));
        chk({tag, "_perr"}, 128'(perr_o[d]), 128'(perr_m[d]));
    endtask

    task automatic model_reset(input int d);
        last[d]   = '0;
        nrd[d]    = 0;
        nwr[d]    = 0;
        perr_m[d] = 1'b0;
    endtask

    // One request from the initiator's view; caller is at a negedge with the DUT idle.
    task automatic txn(input int d, input bit is_wr, input logic [27:0] a, input logic [127:0] wd, input bit drop);
        int  k;
        int  bcnt;
        int  idx;
        bit  seen;
        idx     = int'(a[9:0]);
        rd[d]   = !is_wr;
        wr[d]   = is_wr;
        addr[d] = a;
        wdat[d] = wd;
        seen = 1'b0;
        bcnt = 0;
        k    = 0;
        while (!seen && k < lat[d] + 10) begin
            @(negedge clk);
            k++;
            if (bsy[d]) bcnt++;
            if (rdy[d]) seen = 1'b1;
            if (drop && k == 1) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
            end
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        rcyc[d] = cyc;
        chk("ready_seen", 128'(seen), 128'd1);
        chk("latency", 128'(k), 128'(lat[d]));
        chk("busy_len", 128'(bcnt), 128'(lat[d]));
        if (is_wr) begin
            mm[d][idx]  = wd;
            wrt[d][idx] = 1'b1;
            nwr[d]++;
        end else begin
            last[d] = mm[d][idx];
            nrd[d]++;
        end
        chk("rdata_at_ready", rdat[d], last[d]);
        @(negedge clk);
        chk("pulse_width", 128'(rdy[d]), 128'd0);
        chk("busy_after", 128'(bsy[d]), 128'd0);
        chk_state(d, "post");
    endtask

    task automatic rnd_txns(input int d, input int n);
        logic [27:0]  a;
        logic [127:0] data;
        bit           w;
        bit           dr;
        for (int i = 0; i < n; i++) begin
            a       = 28'($urandom);
            a[9:0]  = 10'($urandom_range(0, 15));
            w       = ($urandom_range(0, 1) == 1) || !wrt[d][int'(a[9:0])];
            dr      = (lat[d] > 1) && ($urandom_range(0, 3) == 0);
            data    = {$urandom, $urandom, $urandom, $urandom};
            txn(d, w, a, data, dr);
        end
    endtask

    localparam logic [127:0] D_A  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D_B  = 128'hCAFEF00D_55AA55AA_DEADBEEF_00FF00FF;
    localparam logic [127:0] D_W1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D_W2 = 128'h99999999_88888888_77777777_66666666;

    initial begin
        int c1;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            rd[d]    = 1'b0;
            wr[d]    = 1'b0;
            addr[d]  = '0;
            wdat[d]  = '0;
            model_reset(d);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", 128'(rdy[d]), 128'd0);
            chk("reset_busy", 128'(bsy[d]), 128'd0);
            chk_state(d, "reset");
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(negedge clk);

        // Write then read the same line.
        txn(0, 1'b1, 28'h0000010, D_A, 1'b0);
        txn(0, 1'b0, 28'h0000010, '0, 1'b0);
        chk("wr_then_rd", rdat[0], D_A);

        // L2 miss pattern: write-back idx 5, then refill from an aliasing address.
        txn(0, 1'b1, 28'h0000005, D_B, 1'b0);
        c1 = rcyc[0];
        txn(0, 1'b0, 28'h0000405, '0, 1'b0);
        chk("b2b_spacing", 128'(rcyc[0] - c1), 128'(lat[0] + 1));
        chk("alias_rd", rdat[0], D_B);

        // Request withdrawn while waiting still completes.
        txn(0, 1'b0, 28'h0000010, '0, 1'b1);

        rnd_txns(0, 30);

        // Both requests high in IDLE: sticky error, no completion.
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        addr[0] = 28'h0000010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("perr_no_ready", 128'(rdy[0]), 128'd0);
        end
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        perr_m[0] = 1'b1;
        @(negedge clk);
        chk("perr_busy", 128'(bsy[0]), 128'd0);
        chk_state(0, "perr");
        repeat (3) @(negedge clk);
        chk("perr_sticky", 128'(perr_o[0]), 128'd1);

        // Reset in the middle of a write: nothing committed, no pulse.
        txn(0, 1'b1, 28'h0000009, D_W1, 1'b0);
        wr[0]   = 1'b1;
        addr[0] = 28'h0001009;
        wdat[0] = D_W2;
        @(negedge clk);
        chk("rst_busy_pre", 128'(bsy[0]), 128'd1);
        @(negedge clk);
        rst_n[0] = 1'b0;
        wr[0]    = 1'b0;
        model_reset(0);
        #1;
        chk("rst_mid_ready", 128'(rdy[0]), 128'd0);
        chk("rst_mid_busy", 128'(bsy[0]), 128'd0);
        chk_state(0, "rst_mid");
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_ready", 128'(rdy[0]), 128'd0);
        end
        rst_n[0] = 1'b1;
        repeat (lat[0] + 2) begin
            @(negedge clk);
            chk("rst_no_pulse", 128'(rdy[0]), 128'd0);
        end
        txn(0, 1'b0, 28'h0000009, '0, 1'b0);
        chk("rst_old_data", rdat[0], D_W1);

        // LATENCY=1 with 4-bit counters: enough writes to wrap.
        for (int i = 0; i < 18; i++) begin
            txn(1, 1'b1, 28'(i), {4{32'(i * 32'h01010101)}}, 1'b0);
        end
        chk("wrap_wrcnt", 128'(wrc[1]), 128'd2);
        txn(1, 1'b0, 28'h0000403, '0, 1'b0);
        rnd_txns(1, 20);

        // LATENCY=7.
        txn(2, 1'b1, 28'h0ABC123, D_A, 1'b0);
        txn(2, 1'b0, 28'h0000123, '0, 1'b1);
        chk("lat7_alias", rdat[2], D_A);
        rnd_txns(2, 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
